// File: rtl/bus_arbiter_pkg.sv
// Shared encodings for the instruction/data bus arbiter: FSM states, owner
// identifiers and the fixed-priority grant helper.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StWaitAddr = 2'd1,
        StWaitData = 2'd2
    } arb_state_e;

    typedef enum logic {
        OwnInst = 1'b0,
        OwnData = 1'b1
    } owner_e;

    // Data side always wins a simultaneous request.
    function automatic owner_e pick_owner(input logic data_req);
        return data_req ? OwnData : OwnInst;
    endfunction

endpackage

// File: rtl/bus_arbiter.sv
// Two-master (instruction, data) to one-slave bus arbiter with fixed data
// priority and a single outstanding transaction.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                resetn,

    input  logic                inst_req,
    input  logic                inst_wr,
    input  logic [1:0]          inst_size,
    input  logic [ADDR_W-1:0]   inst_addr,
    input  logic [DATA_W/8-1:0] inst_wen,
    input  logic [DATA_W-1:0]   inst_wdata,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,

    input  logic                data_req,
    input  logic                data_wr,
    input  logic [1:0]          data_size,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W/8-1:0] data_wen,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,

    output logic                bus_req,
    output logic                bus_wr,
    output logic [1:0]          bus_size,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W/8-1:0] bus_wen,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic                bus_addr_ok,
    input  logic                bus_data_ok,
    input  logic [DATA_W-1:0]   bus_rdata,

    output logic                stallreq_inst,
    output logic                stallreq_data
);

    localparam int unsigned WEN_W = DATA_W / 8;

    arb_state_e          state;
    owner_e              owner;
    logic                lat_wr;
    logic [1:0]          lat_size;
    logic [ADDR_W-1:0]   lat_addr;
    logic [WEN_W-1:0]    lat_wen;
    logic [DATA_W-1:0]   lat_wdata;

    logic                in_idle;
    logic                grant_any;
    logic                grant_data;
    logic                grant_inst;
    logic                resp;
    owner_e              winner;
    logic                sel_wr;
    logic [1:0]          sel_size;
    logic [ADDR_W-1:0]   sel_addr;
    logic [WEN_W-1:0]    sel_wen;
    logic [DATA_W-1:0]   sel_wdata;

    // Handshake outputs are gated by resetn so nothing leaks while reset is held.
    always_comb begin
        in_idle    = (state == StIdle);
        grant_any  = resetn && in_idle && (data_req || inst_req);
        winner     = pick_owner(data_req);
        grant_data = grant_any && (winner == OwnData);
        grant_inst = grant_any && (winner == OwnInst);
        resp       = resetn && (state == StWaitData) && bus_data_ok;

        inst_addr_ok = grant_inst;
        data_addr_ok = grant_data;
        inst_data_ok = resp && (owner == OwnInst);
        data_data_ok = resp && (owner == OwnData);
        inst_rdata   = bus_rdata;
        data_rdata   = bus_rdata;

        stallreq_inst = resetn &&
                        ((inst_req && !inst_addr_ok) ||
                         (!in_idle && (owner == OwnInst) && !inst_data_ok));
        stallreq_data = resetn &&
                        ((data_req && !data_addr_ok) ||
                         (!in_idle && (owner == OwnData) && !data_data_ok));
    end

    always_comb begin
        sel_wr    = inst_wr;
        sel_size  = inst_size;
        sel_addr  = inst_addr;
        sel_wen   = inst_wen;
        sel_wdata = inst_wdata;
        if (winner == OwnData) begin
            sel_wr    = data_wr;
            sel_size  = data_size;
            sel_addr  = data_addr;
            sel_wen   = data_wen;
            sel_wdata = data_wdata;
        end
    end

    always_comb begin
        bus_req   = resetn && (state == StWaitAddr);
        bus_wr    = lat_wr;
        bus_size  = lat_size;
        bus_addr  = lat_addr;
        bus_wen   = lat_wen;
        bus_wdata = lat_wdata;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= StIdle;
            owner     <= OwnInst;
            lat_wr    <= 1'b0;
            lat_size  <= 2'd0;
            lat_addr  <= '0;
            lat_wen   <= '0;
            lat_wdata <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (grant_any) begin
                        owner     <= winner;
                        lat_wr    <= sel_wr;
                        lat_size  <= sel_size;
                        lat_addr  <= sel_addr;
                        lat_wen   <= sel_wen;
                        lat_wdata <= sel_wdata;
                        state     <= StWaitAddr;
                    end
                end
                StWaitAddr: begin
                    if (bus_addr_ok) begin
                        state <= StWaitData;
                    end
                end
                StWaitData: begin
                    if (bus_data_ok) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: transaction-level model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_bus_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, data_addr, inst_wdata, data_wdata;
    logic [3:0]  inst_wen, data_wen;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_wen;
    logic        stallreq_inst, stallreq_data;

    int checks = 0;
    int errors = 0;

    bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wen(inst_wen), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wen(data_wen), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
        .bus_wen(bus_wen), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
        .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
        .stallreq_inst(stallreq_inst), .stallreq_data(stallreq_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: at most one transaction, either awaiting its
    // address handshake or awaiting its response.
    logic        m_busy = 1'b0;
    logic        m_issued = 1'b0;
    logic        m_is_data = 1'b0;
    logic        m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wen;

    always @(negedge clk) begin
        logic e_ia, e_da, e_id, e_dd, e_breq, e_si, e_sd;
        e_ia = 0; e_da = 0; e_id = 0; e_dd = 0; e_breq = 0; e_si = 0; e_sd = 0;
        if (resetn) begin
            if (!m_busy) begin
                e_da = data_req;
                e_ia = inst_req && !data_req;
            end
            e_breq = m_busy && !m_issued;
            e_dd   = m_busy && m_issued && bus_data_ok && m_is_data;
            e_id   = m_busy && m_issued && bus_data_ok && !m_is_data;
            e_si   = (inst_req && !e_ia) || (m_busy && !m_is_data && !e_id);
            e_sd   = (data_req && !e_da) || (m_busy && m_is_data && !e_dd);
        end
        chk("inst_addr_ok", inst_addr_ok, e_ia);
        chk("data_addr_ok", data_addr_ok, e_da);
        chk("inst_data_ok", inst_data_ok, e_id);
        chk("data_data_ok", data_data_ok, e_dd);
        chk("bus_req", bus_req, e_breq);
        chk("stallreq_inst", stallreq_inst, e_si);
        chk("stallreq_data", stallreq_data, e_sd);
        if (e_breq) begin
            chk("bus_wr", bus_wr, m_wr);
            chk("bus_size", bus_size, m_size);
            chk("bus_addr", bus_addr, m_addr);
            chk("bus_wen", bus_wen, m_wen);
            chk("bus_wdata", bus_wdata, m_wdata);
        end
        if (e_id) chk("inst_rdata", inst_rdata, bus_rdata);
        if (e_dd) chk("data_rdata", data_rdata, bus_rdata);

        if (!resetn) begin
            m_busy = 0;
            m_issued = 0;
        end else if (e_da || e_ia) begin
            m_busy    = 1;
            m_issued  = 0;
            m_is_data = e_da;
            m_wr      = e_da ? data_wr    : inst_wr;
            m_size    = e_da ? data_size  : inst_size;
            m_addr    = e_da ? data_addr  : inst_addr;
            m_wen     = e_da ? data_wen   : inst_wen;
            m_wdata   = e_da ? data_wdata : inst_wdata;
        end else if (e_breq && bus_addr_ok) begin
            m_issued = 1;
        end else if (e_id || e_dd) begin
            m_busy = 0;
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    int n_aok, n_dok;

    initial begin
        resetn = 0;
        inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wen = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wen = 0; data_wdata = 0;
        bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
        smp();
        chk("reset_bus_req", bus_req, 0);
        nxt();
        smp();
        chk("reset_stall", {stallreq_inst, stallreq_data}, 0);
        nxt();

        // Single instruction fetch at minimum latency.
        resetn = 1;
        inst_req = 1; inst_addr = 32'hBFC00000; inst_size = 2;
        smp();
        chk("t29_inst_addr_ok", inst_addr_ok, 1);
        nxt();
        inst_req = 0; bus_addr_ok = 1;
        smp();
        chk("t29_bus_req", bus_req, 1);
        chk("t29_bus_addr", bus_addr, 32'hBFC00000);
        nxt();
        bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h3C1D0001;
        smp();
        chk("t29_inst_data_ok", inst_data_ok, 1);
        chk("t29_inst_rdata", inst_rdata, 32'h3C1D0001);
        nxt();
        bus_data_ok = 0;

        // Simultaneous requests: data wins, inst follows right after.
        inst_req = 1; inst_addr = 32'hBFC00004;
        data_req = 1; data_addr = 32'h80001000; data_wr = 0;
        smp();
        chk("t30_data_aok", data_addr_ok, 1);
        chk("t30_inst_aok", inst_addr_ok, 0);
        chk("t30_stall_i0", stallreq_inst, 1);
        nxt();
        data_req = 0; bus_addr_ok = 1;
        smp();
        chk("t30_bus_addr", bus_addr, 32'h80001000);
        chk("t30_stall_i1", stallreq_inst, 1);
        nxt();
        bus_addr_ok = 0; bus_data_ok = 1;
        smp();
        chk("t30_data_dok", data_data_ok, 1);
        chk("t30_stall_i2", stallreq_inst, 1);
        nxt();
        bus_data_ok = 0;
        smp();
        chk("t30_inst_aok_after", inst_addr_ok, 1);
        nxt();
        inst_req = 0; bus_addr_ok = 1;
        smp();
        chk("t30_bus_addr_inst", bus_addr, 32'hBFC00004);
        nxt();
        bus_addr_ok = 0; bus_data_ok = 1;
        smp();
        chk("t30_inst_dok", inst_data_ok, 1);
        nxt();
        bus_data_ok = 0;

        // Data write with three cycles of address backpressure.
        data_req = 1; data_wr = 1; data_addr = 32'h80002000; data_size = 2;
        data_wen = 4'b0011; data_wdata = 32'h12345678;
        smp();
        nxt();
        data_req = 0; data_wen = 4'b1100; data_wdata = 32'hDEADBEEF; data_addr = 32'h0;
        for (int i = 0; i < 4; i++) begin
            bus_addr_ok = (i == 3);
            smp();
            chk("t31_bus_req", bus_req, 1);
            chk("t31_bus_wen", bus_wen, 4'b0011);
            chk("t31_bus_wdata", bus_wdata, 32'h12345678);
            chk("t31_stall_d", stallreq_data, 1);
            nxt();
        end
        bus_addr_ok = 0;
        smp();
        chk("t31_stall_d_wait", stallreq_data, 1);
        nxt();
        bus_data_ok = 1;
        smp();
        chk("t31_data_dok", data_data_ok, 1);
        chk("t31_stall_d_done", stallreq_data, 0);
        nxt();
        bus_data_ok = 0; data_wr = 0; data_wen = 0;

        // Reset while awaiting the response, then a late bus_data_ok.
        inst_req = 1; inst_addr = 32'hBFC00008;
        smp();
        nxt();
        inst_req = 0; bus_addr_ok = 1;
        smp();
        nxt();
        bus_addr_ok = 0; resetn = 0;
        smp();
        chk("t32_rst_stall_i", stallreq_inst, 0);
        nxt();
        resetn = 1; bus_data_ok = 1;
        smp();
        chk("t32_late_dok", inst_data_ok, 0);
        chk("t32_bus_req", bus_req, 0);
        chk("t32_stall_i", stallreq_inst, 0);
        nxt();
        bus_data_ok = 0;

        // Spurious responses in idle and while awaiting the address handshake.
        bus_data_ok = 1;
        smp();
        chk("t33_idle_dok", {inst_data_ok, data_data_ok}, 0);
        nxt();
        bus_data_ok = 0; data_req = 1; data_addr = 32'h80003000;
        smp();
        nxt();
        data_req = 0; bus_data_ok = 1;
        smp();
        chk("t33_wa_dok", data_data_ok, 0);
        nxt();
        bus_data_ok = 0;
        smp();
        chk("t33_still_wa", bus_req, 1);
        nxt();
        bus_addr_ok = 1;
        smp();
        nxt();
        bus_addr_ok = 0; bus_data_ok = 1;
        smp();
        chk("t33_final_dok", data_data_ok, 1);
        nxt();
        bus_data_ok = 0;

        // Back-to-back fetches with an always-ready bus.
        inst_req = 1; bus_addr_ok = 1; bus_data_ok = 1;
        n_aok = 0; n_dok = 0;
        for (int i = 0; i < 30; i++) begin
            smp();
            n_aok += int'(inst_addr_ok);
            n_dok += int'(inst_data_ok);
            nxt();
        end
        chk("t34_grants", n_aok, 10);
        chk("t34_resps", n_dok, 10);
        inst_req = 0; bus_addr_ok = 0; bus_data_ok = 0;

        // Random traffic, including occasional resets and field churn.
        for (int i = 0; i < 3000; i++) begin
            resetn      = ($urandom_range(0, 199) != 0);
            inst_req    = 1'($urandom_range(0, 1));
            data_req    = ($urandom_range(0, 2) == 0);
            inst_wr     = 1'($urandom_range(0, 1));
            data_wr     = 1'($urandom_range(0, 1));
            inst_size   = 2'($urandom_range(0, 3));
            data_size   = 2'($urandom_range(0, 3));
            inst_addr   = $urandom;
            data_addr   = $urandom;
            inst_wen    = 4'($urandom_range(0, 15));
            data_wen    = 4'($urandom_range(0, 15));
            inst_wdata  = $urandom;
            data_wdata  = $urandom;
            bus_addr_ok = ($urandom_range(0, 2) == 0);
            bus_data_ok = ($urandom_range(0, 2) == 0);
            bus_rdata   = $urandom;
            smp();
            nxt();
        end

        smp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
